// File: rtl/cube_line_raster.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cube_line_raster                                             |
// | Description : Fetches N_LINES line endpoints from a geometry source and    |
// |               rasterises each with Bresenham, one pixel per handshake.     |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module cube_line_raster #(
  parameter int XY_BITW = 16,
  parameter int LINEW   = 4,
  parameter int COLORW  = 3,
  parameter int N_LINES = 12,
  parameter int SRC_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LINEW-1:0]   line_id,
  input  logic [XY_BITW-1:0] x0,
  input  logic [XY_BITW-1:0] y0,
  input  logic [XY_BITW-1:0] x1,
  input  logic [XY_BITW-1:0] y1,
  input  logic [COLORW-1:0]  color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [XY_BITW-1:0] pix_x,
  output logic [XY_BITW-1:0] pix_y,
  output logic [COLORW-1:0]  pix_color
);

  localparam int                         c_ew        = XY_BITW + 2;
  localparam logic [2:0]                 c_wait_last = 3'((SRC_LAT > 0) ? SRC_LAT - 1 : 0);
  localparam logic [LINEW-1:0]           c_last_line = LINEW'(N_LINES - 1);
  localparam logic [LINEW-1:0]           c_line_one  = LINEW'(1);
  localparam logic [XY_BITW-1:0]         c_xy_one    = XY_BITW'(1);
  localparam logic signed [c_ew-1:0]     c_err_zero  = '0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    LOAD = 3'd2,
    DRAW = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]               r_wait;
  logic [LINEW-1:0]         r_line_id;
  logic [XY_BITW-1:0]       r_x;
  logic [XY_BITW-1:0]       r_y;
  logic [XY_BITW-1:0]       r_xe;
  logic [XY_BITW-1:0]       r_ye;
  logic [COLORW-1:0]        r_col;
  logic signed [c_ew-1:0]   r_dx;
  logic signed [c_ew-1:0]   r_dy;
  logic signed [c_ew-1:0]   r_err;
  logic                     r_sx_neg;
  logic                     r_sy_neg;

  // Endpoints are zero-extended by two bits so differences and 2*err never wrap.
  logic signed [c_ew-1:0]   w_ddx;
  logic signed [c_ew-1:0]   w_ddy;
  logic signed [c_ew-1:0]   w_dx_abs;
  logic signed [c_ew-1:0]   w_dy_abs;
  logic signed [c_ew-1:0]   w_e2;
  logic signed [c_ew-1:0]   w_err_add_x;
  logic signed [c_ew-1:0]   w_err_add_y;
  logic                     w_step_x;
  logic                     w_step_y;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_more;

  assign w_ddx    = signed'({2'b00, x1}) - signed'({2'b00, x0});
  assign w_ddy    = signed'({2'b00, y1}) - signed'({2'b00, y0});
  assign w_dx_abs = w_ddx[c_ew-1] ? -w_ddx : w_ddx;
  assign w_dy_abs = w_ddy[c_ew-1] ? -w_ddy : w_ddy;

  assign w_e2        = r_err <<< 1;
  assign w_step_x    = (w_e2 >= r_dy);
  assign w_step_y    = (w_e2 <= r_dx);
  assign w_err_add_x = w_step_x ? r_dy : c_err_zero;
  assign w_err_add_y = w_step_y ? r_dx : c_err_zero;

  assign w_hs   = (r_state == DRAW) && pix_ready;
  assign w_last = (r_x == r_xe) && (r_y == r_ye);
  assign w_more = (r_line_id < c_last_line);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (SRC_LAT == 0) w_state_nxt = LOAD;
          else              w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (r_wait == c_wait_last) w_state_nxt = LOAD;
      end
      LOAD: w_state_nxt = DRAW;
      DRAW: begin
        if (w_hs && w_last) begin
          if (!w_more)           w_state_nxt = FIN;
          else if (SRC_LAT == 0) w_state_nxt = LOAD;
          else                   w_state_nxt = REQ;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait    <= '0;
      r_line_id <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_xe      <= '0;
      r_ye      <= '0;
      r_col     <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_err     <= '0;
      r_sx_neg  <= 1'b0;
      r_sy_neg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_line_id <= '0;
            r_wait    <= '0;
          end
        end
        REQ: r_wait <= r_wait + 3'd1;
        LOAD: begin
          r_x      <= x0;
          r_y      <= y0;
          r_xe     <= x1;
          r_ye     <= y1;
          r_col    <= color;
          r_dx     <= w_dx_abs;
          r_dy     <= -w_dy_abs;
          r_err    <= w_dx_abs - w_dy_abs;
          r_sx_neg <= !(x0 < x1);
          r_sy_neg <= !(y0 < y1);
        end
        DRAW: begin
          if (w_hs) begin
            if (w_last) begin
              if (w_more) begin
                r_line_id <= r_line_id + c_line_one;
                r_wait    <= '0;
              end
            end else begin
              // Both axis steps are evaluated against the same e2.
              r_err <= r_err + w_err_add_x + w_err_add_y;
              if (w_step_x) r_x <= r_sx_neg ? (r_x - c_xy_one) : (r_x + c_xy_one);
              if (w_step_y) r_y <= r_sy_neg ? (r_y - c_xy_one) : (r_y + c_xy_one);
            end
          end
        end
        FIN:     r_line_id <= '0;
        default: r_line_id <= '0;
      endcase
    end
  end

  assign busy      = (r_state == REQ) || (r_state == LOAD) || (r_state == DRAW);
  assign done      = (r_state == FIN);
  assign pix_valid = (r_state == DRAW);
  assign line_id   = r_line_id;
  assign pix_x     = r_x;
  assign pix_y     = r_y;
  assign pix_color = r_col;

endmodule
`default_nettype wire

// File: doc/cube_line_raster.md
CUBE_LINE_RASTER -- requirements
Module: cube_line_raster

Interface
REQ-001 SHALL have parameter XY_BITW, default 16, meaning the coordinate width.
REQ-002 SHALL have parameter LINEW, default 4, meaning the line index width.
REQ-003 SHALL have parameter COLORW, default 3, meaning the color width.
REQ-004 SHALL have parameter N_LINES, default 12, meaning the number of lines drawn per frame.
REQ-005 SHALL have parameter SRC_LAT, default 1, meaning the number of cycles from a line_id change until the endpoint/color inputs are valid; allowed range is 0 to 7.
REQ-006 SHALL have port clk, input, 1 bit: the clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: a one-cycle request to draw all lines.
REQ-009 SHALL have port busy, output, 1 bit: high from acceptance of start until done.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse after the last pixel is accepted.
REQ-011 SHALL have port line_id, output, LINEW bits: the index of the line requested from the cube geometry source.
REQ-012 SHALL have ports x0, y0, x1, y1, input, XY_BITW bits each, unsigned: the line endpoints from the source.
REQ-013 SHALL have port color, input, COLORW bits: the line color from the source.
REQ-014 SHALL have port pix_valid, output, 1 bit: pixel output valid.
REQ-015 SHALL have port pix_ready, input, 1 bit: downstream accepts the pixel.
REQ-016 SHALL have ports pix_x and pix_y, output, XY_BITW bits each, plus pix_color, output, COLORW bits: the pixel payload.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, LOAD, DRAW and FIN.
REQ-018 SHALL, in IDLE when start=1, set busy=1, set line_id=0, clear the wait counter and go to REQ; start SHALL be ignored in every other state.
REQ-019 SHALL stay in REQ for exactly SRC_LAT cycles (zero when SRC_LAT=0), holding line_id stable, then go to LOAD.
REQ-020 SHALL, in LOAD, latch x=x0, y=y0, xe=x1, ye=y1 and col=color for one cycle.
REQ-021 SHALL, in LOAD, compute dx=|x1-x0| and dy=-|y1-y0|, set sx=+1 if x0<x1 else -1, set sy=+1 if y0<y1 else -1, set err=dx+dy, and then go to DRAW.
REQ-022 SHALL make dx, dy, err and e2 signed and XY_BITW+2 bits wide, with no overflow for any unsigned XY_BITW input.
REQ-023 SHALL, in DRAW, assert pix_valid=1 with pix_x=x, pix_y=y and pix_color=col.
REQ-024 SHALL hold the payload stable while pix_valid=1 and pix_ready=0, with no state advance in that case.
REQ-025 SHALL, on a handshake (pix_valid and pix_ready both high) that is not the last pixel, set e2=2*err and then apply both of the following independently in the same cycle:
  - if e2>=dy: err+=dy and x+=sx;
  - if e2<=dx: err+=dx and y+=sy.
REQ-026 SHALL treat a handshake with x==xe and y==ye as the last pixel of the line: if line_id<N_LINES-1, increment line_id and go to REQ; otherwise go to FIN.
REQ-027 SHALL emit exactly max(|dx|,|dy|)+1 pixels per line, starting at (x0,y0) and ending at (x1,y1).
REQ-028 SHALL emit exactly one pixel for a degenerate line (x0==x1 and y0==y1).
REQ-029 SHALL sustain one pixel per cycle while pix_ready=1, with a per-line overhead of SRC_LAT+1 cycles (pix_valid=0 during REQ and LOAD).
REQ-030 SHALL, in FIN, pulse done=1 for one cycle, set busy=0, set line_id=0 and return to IDLE.
REQ-031 SHALL keep pix_valid=0 in all states other than DRAW.
REQ-032 SHALL not require the endpoint inputs to stay stable outside the LOAD cycle.

Reset
REQ-033 SHALL, while rst=1 asynchronously, force state=IDLE and set busy, done, pix_valid, line_id, pix_x, pix_y, pix_color and all internal registers to 0.
REQ-034 SHALL, on assertion of rst mid-line, drop pix_valid immediately, emit no further pixels of that frame, and require a new start afterwards to draw again from line 0.

Verification
REQ-035 SHALL be verified by a reset scenario: assert rst with clk running -> all outputs 0; after release, no activity until start.
REQ-036 SHALL be verified by a horizontal-line scenario: source returns (0,0)->(3,0), pix_ready=1, SRC_LAT=1 -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles, with first pix_valid 2 cycles after REQ entry.
REQ-037 SHALL be verified by a reversed-diagonal scenario: (3,3)->(0,0) -> pixels (3,3),(2,2),(1,1),(0,0); also (0,0)->(1,3) -> pixels (0,0),(0,1),(1,2),(1,3).
REQ-038 SHALL be verified by a backpressure scenario: pix_ready low for 5 cycles mid-line -> payload held, no pixel dropped or duplicated, and the sequence matches the pix_ready=1 reference.
REQ-039 SHALL be verified by a full-cube scenario: connect to the cube geometry source (WIDTH=10, HEIGHT=10, DEPTH=5, SCALE=1) -> line_id visits 0..11 in order, the total pixel count equals the sum over lines of max(|dx|,|dy|)+1, and done pulses exactly once.
REQ-040 SHALL be verified by a start/reset interaction scenario: start pulsed while busy -> no effect; rst mid-DRAW -> pix_valid=0 in the same cycle and state IDLE; a following start -> line_id=0 and drawing restarts.
